// File: rtl/coreabc_ifetch_pkg.sv
// Shared CoreABC fetch definitions: sequencer states, prefetch buffer depth
// and the issue-throttle helper.
package coreabc_ifetch_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A new read may issue only if buffered + in-flight words, less this cycle's pop, leave a slot.
    function automatic logic has_room(input logic [CNT_W-1:0] count,
                                      input logic             inflight,
                                      input logic             pop);
        logic [CNT_W:0] occ;
        occ = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        return occ < (CNT_W+1)'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/coreabc_ifetch_fifo.sv
// Two-entry prefetch buffer holding {pc, instruction}; head always in head_q.
module coreabc_ifetch_fifo
    import coreabc_ifetch_pkg::*;
#(
    parameter int unsigned W = 24
) (
    input  logic             RWCLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     head_q;
    logic [W-1:0]     tail_q;
    logic             pop_ok;
    logic             push_ok;
    logic [CNT_W-1:0] base;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign rdata   = head_q;
    assign pop_ok  = pop && !empty;
    assign base    = count - CNT_W'(pop_ok);
    assign push_ok = push && (base < CNT_W'(FIFO_DEPTH));

    // Pop shifts tail into head; push writes the first slot free after the pop.
    always_ff @(posedge RWCLK) begin
        if (!RESET) begin
            count  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop_ok && full) begin
                head_q <= tail_q;
            end
            if (push_ok) begin
                if (base == '0) begin
                    head_q <= wdata;
                end else begin
                    tail_q <= wdata;
                end
            end
            count <= base + CNT_W'(push_ok);
        end
    end

endmodule

// File: rtl/coreabc_ifetch.sv
// CoreABC instruction fetch: issues RAM reads, buffers returns in a 2-entry
// FIFO and hands instructions to the decoder with valid/ready.
module coreabc_ifetch
    import coreabc_ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              RWCLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              JUMP,
    input  logic [ADDR_W-1:0] JUMP_ADDR,
    output logic              REN,
    output logic [ADDR_W-1:0] RADDR,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY
);

    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  head;

    // A JUMP kills the word landing this cycle and hides the head from the decoder.
    assign INSTR_VALID = !fifo_empty && !JUMP;
    assign pop         = INSTR_VALID && INSTR_READY;
    assign push        = inflight && !JUMP && (!fifo_full || pop);
    assign INSTR       = fifo_empty ? '0 : head[DATA_W-1:0];
    assign INSTR_PC    = fifo_empty ? '0 : head[ENT_W-1:DATA_W];

    coreabc_ifetch_fifo #(
        .W (ENT_W)
    ) u_fifo (
        .RWCLK (RWCLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .flush (JUMP),
        .wdata ({inflight_pc, RD}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequencer and read issue; a jump in RUN issues its target even as ENABLE drops.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        REN       = 1'b0;
        RADDR     = '0;
        case (state)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_nxt = ST_RUN;
                end
                if (JUMP) begin
                    pc_nxt = JUMP_ADDR;
                end
            end
            ST_RUN: begin
                if (!ENABLE) begin
                    state_nxt = ST_IDLE;
                end
                if (JUMP) begin
                    REN    = 1'b1;
                    RADDR  = JUMP_ADDR;
                    pc_nxt = JUMP_ADDR + ADDR_W'(1);
                end else if (ENABLE && has_room(fifo_count, inflight, pop)) begin
                    REN    = 1'b1;
                    RADDR  = pc;
                    pc_nxt = pc + ADDR_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge RWCLK) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            pc          <= ADDR_W'(START_ADDR);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inflight <= REN;
            if (REN) begin
                inflight_pc <= RADDR;
            end
        end
    end

endmodule

// File: tb/tb_coreabc_ifetch.sv
// Bench for coreabc_ifetch: stream-order scoreboard checked every cycle plus
// directed scenarios with literal expectations.
module tb_coreabc_ifetch;

    localparam logic [7:0] START = 8'h10;

    logic        RWCLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        JUMP;
    logic [7:0]  JUMP_ADDR;
    logic        REN;
    logic [7:0]  RADDR;
    logic [15:0] RD = 16'h0000;
    logic [15:0] INSTR;
    logic [7:0]  INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;

    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic [7:0]  exp_pc = START;
    int          live   = 0;

    coreabc_ifetch #(
        .ADDR_W     (8),
        .DATA_W     (16),
        .START_ADDR (int'(START))
    ) dut (
        .RWCLK       (RWCLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .JUMP        (JUMP),
        .JUMP_ADDR   (JUMP_ADDR),
        .REN         (REN),
        .RADDR       (RADDR),
        .RD          (RD),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY)
    );

    always #5 RWCLK = ~RWCLK;

    // RAM image mem[i] = 0x0100 + i, one-cycle read latency; junk when not read.
    always @(posedge RWCLK) RD <= REN ? (16'h0100 + 16'(RADDR)) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: transfers must follow the address stream from the last reset/jump.
    always @(negedge RWCLK) begin
        if (mon_on) begin
            if (!RESET) begin
                exp_pc = START;
                live   = 0;
            end else if (JUMP) begin
                chk("jump_valid_low", 32'(INSTR_VALID), 32'd0);
                exp_pc = JUMP_ADDR;
                live   = int'(REN);
            end else begin
                if (INSTR_VALID && INSTR_READY) begin
                    chk("stream_pc", 32'(INSTR_PC), 32'(exp_pc));
                    chk("stream_instr", 32'(INSTR), 32'(16'h0100 + 16'(exp_pc)));
                    exp_pc = exp_pc + 8'd1;
                    live--;
                end
                if (REN) live++;
                chk("occupancy", 32'(live >= 0 && live <= 2), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge RWCLK);
        #1;
    endtask

    task automatic run_cycles(input int n, output int n_ren, output int n_valid, output int n_xfer);
        n_ren = 0; n_valid = 0; n_xfer = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge RWCLK);
            n_ren   += int'(REN);
            n_valid += int'(INSTR_VALID);
            n_xfer  += int'(INSTR_VALID && INSTR_READY);
            step();
        end
    endtask

    task automatic wait_xfer(output logic [7:0] pc, output logic [15:0] ins);
        bit found;
        found = 1'b0;
        pc    = 'x;
        ins   = 'x;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge RWCLK);
            if (INSTR_VALID && INSTR_READY) begin
                found = 1'b1;
                pc    = INSTR_PC;
                ins   = INSTR;
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nr, nv, nx;
        int         ren_cyc, val_cyc;
        logic [7:0]  pc;
        logic [15:0] ins;
        logic [15:0] first_ins;
        logic [7:0]  first_pc;

        RESET = 1'b0; ENABLE = 1'b0; JUMP = 1'b0; JUMP_ADDR = 8'h00; INSTR_READY = 1'b1;
        step();
        step();
        @(negedge RWCLK);
        chk("rst_ren", 32'(REN), 32'd0);
        chk("rst_raddr", 32'(RADDR), 32'd0);
        chk("rst_instr", 32'(INSTR), 32'd0);
        chk("rst_instr_pc", 32'(INSTR_PC), 32'd0);
        chk("rst_valid", 32'(INSTR_VALID), 32'd0);
        step();

        // Start-up latency and first word.
        RESET = 1'b1; ENABLE = 1'b1; mon_on = 1'b1;
        ren_cyc = -1; val_cyc = -1; first_ins = 'x; first_pc = 'x;
        for (int i = 0; i < 12 && val_cyc < 0; i++) begin
            @(negedge RWCLK);
            if (REN && ren_cyc < 0) ren_cyc = i;
            if (INSTR_VALID && val_cyc < 0) begin
                val_cyc   = i;
                first_ins = INSTR;
                first_pc  = INSTR_PC;
            end
            step();
        end
        chk("first_valid_latency", 32'(val_cyc - ren_cyc), 32'd2);
        chk("first_instr", 32'(first_ins), 32'h0110);
        chk("first_pc", 32'(first_pc), 32'h10);
        run_cycles(8, nr, nv, nx);
        chk("throughput", 32'(nx), 32'd8);

        // Decoder stall: buffer fills, issue stops, resume without gap.
        INSTR_READY = 1'b0;
        run_cycles(6, nr, nv, nx);
        chk("stall_ren", 32'(nr), 32'd0);
        chk("stall_valid", 32'(nv), 32'd6);
        INSTR_READY = 1'b1;
        run_cycles(6, nr, nv, nx);
        chk("resume_xfer", 32'(nx), 32'd6);
        chk("resume_ren", 32'(nr), 32'd6);

        // Jump with a full buffer.
        INSTR_READY = 1'b0;
        run_cycles(3, nr, nv, nx);
        JUMP = 1'b1; JUMP_ADDR = 8'h80;
        @(negedge RWCLK);
        chk("jump_full_valid", 32'(INSTR_VALID), 32'd0);
        chk("jump_full_ren", 32'(REN), 32'd1);
        chk("jump_full_raddr", 32'(RADDR), 32'h80);
        step();
        JUMP = 1'b0; INSTR_READY = 1'b1;
        wait_xfer(pc, ins);
        chk("jump_full_pc", 32'(pc), 32'h80);
        chk("jump_full_instr", 32'(ins), 32'h0180);

        // Jump mid-stream near the top of the address space: wrap.
        run_cycles(3, nr, nv, nx);
        JUMP = 1'b1; JUMP_ADDR = 8'hFE;
        step();
        JUMP = 1'b0;
        wait_xfer(pc, ins);
        chk("wrap_pc0", 32'(pc), 32'hFE);
        wait_xfer(pc, ins);
        chk("wrap_pc1", 32'(pc), 32'hFF);
        wait_xfer(pc, ins);
        chk("wrap_pc2", 32'(pc), 32'h00);
        chk("wrap_instr2", 32'(ins), 32'h0100);
        wait_xfer(pc, ins);
        chk("wrap_pc3", 32'(pc), 32'h01);

        // One-cycle reset mid-stream.
        run_cycles(2, nr, nv, nx);
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        @(negedge RWCLK);
        chk("mid_rst_ren", 32'(REN), 32'd0);
        chk("mid_rst_raddr", 32'(RADDR), 32'd0);
        chk("mid_rst_instr", 32'(INSTR), 32'd0);
        chk("mid_rst_instr_pc", 32'(INSTR_PC), 32'd0);
        chk("mid_rst_valid", 32'(INSTR_VALID), 32'd0);
        step();
        wait_xfer(pc, ins);
        chk("restart_pc", 32'(pc), 32'h10);
        chk("restart_instr", 32'(ins), 32'h0110);

        // ENABLE falls with one read in flight.
        run_cycles(3, nr, nv, nx);
        ENABLE = 1'b0;
        run_cycles(6, nr, nv, nx);
        chk("disable_ren", 32'(nr), 32'd0);
        chk("disable_xfer", 32'(nx), 32'd2);

        // Jump while idle only redirects the PC.
        JUMP = 1'b1; JUMP_ADDR = 8'h40;
        @(negedge RWCLK);
        chk("idle_jump_ren", 32'(REN), 32'd0);
        step();
        JUMP = 1'b0; ENABLE = 1'b1;
        wait_xfer(pc, ins);
        chk("idle_jump_pc", 32'(pc), 32'h40);
        chk("idle_jump_instr", 32'(ins), 32'h0140);
        run_cycles(4, nr, nv, nx);
        chk("final_xfer", 32'(nx), 32'd4);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coreabc_ifetch.md
COREABC_IFETCH -- requirements
Module: coreabc_ifetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, the instruction word width.
REQ-003 SHALL have parameter START_ADDR, default 0, the first fetch address after reset.
REQ-004 SHALL have port RWCLK  in  1  the single clock; all logic rises on it.
REQ-005 SHALL have port RESET  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port ENABLE  in  1  fetch enable from the sequencer.
REQ-007 SHALL have port JUMP  in  1  redirect strobe, one cycle.
REQ-008 SHALL have port JUMP_ADDR  in  ADDR_W  redirect target.
REQ-009 SHALL have port REN  out  1  RAM read enable.
REQ-010 SHALL have port RADDR  out  ADDR_W  RAM read address.
REQ-011 SHALL have port RD  in  DATA_W  RAM read data, valid one cycle after REN.
REQ-012 SHALL have port INSTR  out  DATA_W  instruction to decoder.
REQ-013 SHALL have port INSTR_PC  out  ADDR_W  address of INSTR.
REQ-014 SHALL have port INSTR_VALID  out  1  INSTR/INSTR_PC valid.
REQ-015 SHALL have port INSTR_READY  in  1  decoder accepts; transfer when VALID and READY both high.

Function
REQ-016 SHALL hold a PC register, the next address to issue; PC increments modulo 2^ADDR_W (0xFF -> 0x00).
REQ-017 SHALL implement FSM IDLE -> RUN when ENABLE=1; RUN -> IDLE when ENABLE=0 (in-flight read still lands in the buffer).
REQ-018 SHALL drive REN/RADDR combinationally from registered state; REN=1 only in RUN when buffer_count + inflight - pop < 2.
REQ-019 SHALL capture RD into a 2-entry FIFO (data + PC) in the cycle after each REN, unless killed by JUMP.
REQ-020 SHALL present the FIFO head on INSTR/INSTR_PC with INSTR_VALID=1 while FIFO is non-empty and JUMP=0.
REQ-021 SHALL sustain one instruction per cycle with INSTR_READY held high; first INSTR_VALID exactly 2 cycles after the first REN edge is taken (1 RAM + 1 FIFO register).
REQ-022 SHALL never overflow the FIFO, drop, or duplicate an instruction under any INSTR_READY pattern.
REQ-023 On JUMP=1: force INSTR_VALID=0 that cycle (no transfer), flush the FIFO, mark the in-flight read killed, drive RADDR=JUMP_ADDR with REN=1 if in RUN, and load PC=JUMP_ADDR+1 (or JUMP_ADDR if not issued).
REQ-024 JUMP SHALL take priority over pop and over ENABLE falling in the same cycle.
REQ-025 A JUMP in IDLE SHALL only load PC=JUMP_ADDR and flush.

Reset
REQ-026 While RESET=0 at a RWCLK edge: state=IDLE, PC=START_ADDR, FIFO empty, inflight/kill cleared.
REQ-027 Output reset values: REN=0, RADDR=0, INSTR=0, INSTR_PC=0, INSTR_VALID=0.
REQ-028 Reset asserted mid-fetch SHALL discard any RD returned in the following cycle.

Structure
REQ-029 FSM state encodings and FIFO depth constant (2) SHALL live in the shared CoreABC package.
REQ-030 The 2-entry FIFO SHALL be a sub-module named coreabc_ifetch_fifo (push, pop, flush, full, empty, count).
REQ-031 The RAM SHALL stay outside the block; no memory is inferred inside it.

Verification
REQ-032 RAM mem[i]=0x0100+i, ENABLE=1, READY=1 from reset -> INSTR 0x0100,0x0101,... with INSTR_PC 0,1,... one per cycle, first valid 2 cycles after first REN.
REQ-033 READY=0 for 6 cycles mid-stream -> REN drops after 2 buffered words; on READY=1 sequence resumes with no gap, loss or duplicate.
REQ-034 FIFO full + read in flight, JUMP with JUMP_ADDR=0x80 -> VALID=0 that cycle, next transferred INSTR=0x0180, INSTR_PC=0x80; no stale word appears.
REQ-035 JUMP to 0xFE -> INSTR_PC sequence 0xFE,0xFF,0x00,0x01.
REQ-036 RESET=0 for one cycle mid-stream with START_ADDR=0x10 -> all outputs 0 next cycle, fetch restarts at 0x10, returned RD discarded.
REQ-037 ENABLE falls with one read in flight -> that word is delivered, then no further REN until ENABLE=1.
